// File: rtl/pix_word_packer.sv
// pix_word_packer: packs 12-bit pixels LSB-first into 16-bit words
// (4 pixels -> 3 words). An end-of-frame flush emits any residue as a
// zero-padded word and reports the frame pixel count.
// Optional build macro: PIX_WORD_PACKER_BSWAP_EN byte-swaps every output
// word at the register input.
module pix_word_packer #(
  parameter int CountWidth = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           px_d,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic                  flush,
  output logic [15:0]           word,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  flush_done,
  output logic [CountWidth-1:0] px_count
);

  logic [15:0]           word_q, word_d;
  logic                  wvld_q, wvld_d;
  logic [11:0]           res_q, res_d;
  logic [3:0]            nbits_q, nbits_d;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;
  logic [CountWidth-1:0] final_q, final_d;

  logic slot_free;
  logic accept;
  logic flush_fire;

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] c);
    sat_inc = (c == {CountWidth{1'b1}}) ? c : c + 1'b1;
  endfunction

  function automatic logic [15:0] out_order(input logic [15:0] w);
`ifdef PIX_WORD_PACKER_BSWAP_EN
    out_order = {w[7:0], w[15:8]};
`else
    out_order = w;
`endif
  endfunction

  assign slot_free  = !wvld_q || word_ready;
  assign px_ready   = slot_free && !pend_q;
  assign accept     = px_valid && px_ready;
  // Pixels are never accepted while pending, so accept and flush_fire are exclusive.
  assign flush_fire = pend_q && slot_free;

  assign word       = word_q;
  assign word_valid = wvld_q;
  assign flush_done = done_q;
  // The counter clears at the flush edge; show the frozen frame total during the pulse.
  assign px_count   = done_q ? final_q : cnt_q;

  // Next-state: residue packing, output slot handshake and flush sequencing.
  always_comb begin
    word_d  = word_q;
    wvld_d  = wvld_q && !word_ready;
    res_d   = res_q;
    nbits_d = nbits_q;
    pend_d  = pend_q || flush;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    final_d = final_q;

    if (accept) begin
      cnt_d = sat_inc(cnt_q);
      // Residue bits above nbits are kept zero so a flush can emit it directly.
      case (nbits_q)
        4'd0: begin
          res_d   = px_d;
          nbits_d = 4'd12;
        end
        4'd12: begin
          word_d  = out_order({px_d[3:0], res_q});
          wvld_d  = 1'b1;
          res_d   = {4'b0, px_d[11:4]};
          nbits_d = 4'd8;
        end
        4'd8: begin
          word_d  = out_order({px_d[7:0], res_q[7:0]});
          wvld_d  = 1'b1;
          res_d   = {8'b0, px_d[11:8]};
          nbits_d = 4'd4;
        end
        default: begin
          word_d  = out_order({px_d, res_q[3:0]});
          wvld_d  = 1'b1;
          res_d   = 12'b0;
          nbits_d = 4'd0;
        end
      endcase
    end

    if (flush_fire) begin
      if (nbits_q != 4'd0) begin
        word_d = out_order({4'b0, res_q});
        wvld_d = 1'b1;
      end
      res_d   = 12'b0;
      nbits_d = 4'd0;
      pend_d  = 1'b0;
      done_d  = 1'b1;
      final_d = cnt_q;
      cnt_d   = '0;
    end
  end

  // State registers; reset discards any residue and any word in the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= 16'b0;
      wvld_q  <= 1'b0;
      res_q   <= 12'b0;
      nbits_q <= 4'd0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      final_q <= '0;
    end else begin
      word_q  <= word_d;
      wvld_q  <= wvld_d;
      res_q   <= res_d;
      nbits_q <= nbits_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      final_q <= final_d;
    end
  end

endmodule

// File: tb/tb_pix_word_packer.sv
// Directed bench for pix_word_packer (small counter width to reach saturation).
module tb_pix_word_packer;

  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic [11:0]   px_d;
  logic          px_valid;
  logic          px_ready;
  logic          flush;
  logic [15:0]   word;
  logic          word_valid;
  logic          word_ready;
  logic          flush_done;
  logic [CW-1:0] px_count;

  int checks;
  int errors;
  logic [15:0] hs_q[$];

  pix_word_packer #(.CountWidth(CW)) dut (
    .clk(clk), .rst(rst), .px_d(px_d), .px_valid(px_valid), .px_ready(px_ready),
    .flush(flush), .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .flush_done(flush_done), .px_count(px_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record words that will be handed off at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) hs_q.push_back(word);
  end

  function automatic logic [15:0] ew(input logic [15:0] w);
`ifdef PIX_WORD_PACKER_BSWAP_EN
    ew = {w[7:0], w[15:8]};
`else
    ew = w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hs(input string tag, input int n, input logic [15:0] w0,
                          input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] exp_w[3];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
    check({tag, "_nwords"}, hs_q.size(), n);
    for (int i = 0; i < n && i < hs_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), hs_q[i], ew(exp_w[i]));
    hs_q.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; px_d = 12'h0; px_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with a word held in the slot
    px_valid = 1'b1; px_d = 12'hABC; tick();
    px_d = 12'h123; tick();
    px_valid = 1'b0; word_ready = 1'b0;
    check("pre_rst_wvld", word_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_wvld", word_valid, 0);
    check("rst_word", word, 0);
    check("rst_pxready", px_ready, 1);
    check("rst_count", px_count, 0);
    check("rst_done", flush_done, 0);
    tick();
    rst = 1'b0; word_ready = 1'b1;
    tick();
    hs_q.delete();

    // Basic pack: the residue starts empty after reset
    px_valid = 1'b1; px_d = 12'hABC; tick();
    check("bp_wvld0", word_valid, 0);
    check("bp_cnt1", px_count, 1);
    px_d = 12'h123; tick();
    check("bp_word1", word, ew(16'h3ABC));
    px_d = 12'h456; tick();
    check("bp_word2", word, ew(16'h5612));
    px_d = 12'h789; tick();
    check("bp_word3", word, ew(16'h7894));
    check("bp_cnt4", px_count, 4);
    px_valid = 1'b0; tick();
    check("bp_wvld_clr", word_valid, 0);
    check_hs("bp", 3, 16'h3ABC, 16'h5612, 16'h7894);

    // Flush with empty residue: no word, one pulse carrying the count
    flush = 1'b1; tick();
    flush = 1'b0;
    check("fe_pxready", px_ready, 0);
    check("fe_done0", flush_done, 0);
    tick();
    check("fe_done", flush_done, 1);
    check("fe_cnt", px_count, 4);
    check("fe_wvld", word_valid, 0);
    tick();
    check("fe_done_clr", flush_done, 0);
    check("fe_cnt_clr", px_count, 0);
    check("fe_pxready1", px_ready, 1);
    check_hs("fe", 0, 16'h0, 16'h0, 16'h0);

    // Backpressure: slot held for 5 cycles, no pixel lost
    px_valid = 1'b1; px_d = 12'hABC; tick();
    px_d = 12'h123; tick();
    word_ready = 1'b0; px_d = 12'h456;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bk_pxready_%0d", i), px_ready, 0);
      check($sformatf("bk_word_%0d", i), word, ew(16'h3ABC));
      check($sformatf("bk_wvld_%0d", i), word_valid, 1);
      tick();
    end
    check("bk_cnt_hold", px_count, 2);
    word_ready = 1'b1; #1;
    check("bk_pxready_rel", px_ready, 1);
    tick();
    check("bk_word2", word, ew(16'h5612));
    px_d = 12'h789; tick();
    check("bk_word3", word, ew(16'h7894));
    check("bk_cnt", px_count, 4);
    px_valid = 1'b0; tick();
    check_hs("bk", 3, 16'h3ABC, 16'h5612, 16'h7894);
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    check("bk_fdone_cnt", px_count, 4);
    tick();
    hs_q.delete();

    // Flush partial: residue 0x12 emitted zero-padded
    px_valid = 1'b1; px_d = 12'hABC; tick();
    px_d = 12'h123; tick();
    px_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    check("fp_done0", flush_done, 0);
    tick();
    check("fp_done", flush_done, 1);
    check("fp_cnt", px_count, 2);
    check("fp_word", word, ew(16'h0012));
    check("fp_wvld", word_valid, 1);
    tick();
    check("fp_done_clr", flush_done, 0);
    check("fp_cnt_clr", px_count, 0);
    check_hs("fp", 2, 16'h3ABC, 16'h0012, 16'h0);

    // Coincident: 4th pixel arrives with flush, completes a word, no flush word
    px_valid = 1'b1; px_d = 12'hABC; tick();
    px_d = 12'h123; tick();
    px_d = 12'h456; tick();
    px_d = 12'h789; flush = 1'b1; tick();
    px_valid = 1'b0; flush = 1'b0;
    check("cc_word", word, ew(16'h7894));
    check("cc_pxready", px_ready, 0);
    tick();
    check("cc_done", flush_done, 1);
    check("cc_cnt", px_count, 4);
    check("cc_wvld", word_valid, 0);
    tick();
    check_hs("cc", 3, 16'h3ABC, 16'h5612, 16'h7894);

    // Coincident with residue left; second flush while pending is ignored
    px_valid = 1'b1; px_d = 12'hDEF; flush = 1'b1; tick();
    px_valid = 1'b0; flush = 1'b1;
    check("cr_cnt", px_count, 1);
    tick();
    flush = 1'b0;
    check("cr_done", flush_done, 1);
    check("cr_cnt_pulse", px_count, 1);
    check("cr_word", word, ew(16'h0DEF));
    tick();
    check("cr_done_once", flush_done, 0);
    check("cr_pxready", px_ready, 1);
    tick();
    check("cr_done_still0", flush_done, 0);
    check_hs("cr", 1, 16'h0DEF, 16'h0, 16'h0);

    // Counter saturation at 2^CW-1
    px_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      px_d = 12'(i); tick();
    end
    px_valid = 1'b0;
    check("sat_cnt", px_count, 7);
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    check("sat_done_cnt", px_count, 7);
    tick();
    check("sat_clr", px_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
